// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state encoding and saturation helper for the convolution window sequencer
package conv_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BIT = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int ACC_GUARD = 8;
  localparam int TAPS = KERNEL_SIZE ** 2;
  typedef enum logic [2:0] {IDLE, LOAD_W, READY, RUN, DRAIN, OUT} state_e;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] a, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return a > hi ? hi : a < lo ? lo : a;
  endfunction
endpackage

// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if: weight, pixel and result handshakes plus status of the window sequencer
interface conv_window_sequencer_if #(parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH);
  logic cfg_load, w_valid, w_ready, pix_valid, pix_ready, out_valid, out_ready, weights_loaded, busy;
  logic [DATA_WIDTH-1:0] w_data, pix_data, out_data;
  modport master(
    output cfg_load, w_valid, w_data, pix_valid, pix_data, out_ready,
    input w_ready, pix_ready, out_valid, out_data, weights_loaded, busy
  );
  modport slave(
    input cfg_load, w_valid, w_data, pix_valid, pix_data, out_ready,
    output w_ready, pix_ready, out_valid, out_data, weights_loaded, busy
  );
endinterface

// File: rtl/conv_window_sequencer_mac_lane.sv
// mac_lane: registered multiply, Q-format truncation and guarded accumulation for one tap per cycle
module mac_lane #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int FRAC_BIT = conv_pkg::FRAC_BIT,
  parameter int ACC_GUARD = conv_pkg::ACC_GUARD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic signed [DATA_WIDTH-1:0] pix,
  input  logic signed [DATA_WIDTH-1:0] w,
  output logic signed [DATA_WIDTH+ACC_GUARD-1:0] acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic prod_valid;
  logic signed [DATA_WIDTH-1:0] trunc;
  logic unused_prod;
  // keep the sign, drop the fraction and the overflow bits above the result word
  assign trunc = {prod[2*DATA_WIDTH-1], prod[DATA_WIDTH+FRAC_BIT-2:FRAC_BIT]};
  assign unused_prod = ^{prod[FRAC_BIT-1:0], prod[2*DATA_WIDTH-2:DATA_WIDTH+FRAC_BIT-1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      prod_valid <= 1'b0;
      acc <= '0;
    end else begin
      prod_valid <= en;
      if (en) prod <= pix * w;
      acc <= clear ? '0 : prod_valid ? acc + {{ACC_GUARD{trunc[DATA_WIDTH-1]}}, trunc} : acc;
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: time-multiplexed KxK convolution window with one shared MAC lane
// Define CONV_SEQ_RELU_EN to clamp negative window sums to zero.
module conv_window_sequencer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int FRAC_BIT = conv_pkg::FRAC_BIT,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int ACC_GUARD = conv_pkg::ACC_GUARD
) (
  input logic clk,
  input logic reset,
  conv_window_sequencer_if.slave bus
);
  import conv_pkg::*;
  localparam int TAPS = KERNEL_SIZE ** 2;
  localparam int TW = $clog2(TAPS + 1);
  state_e state;
  logic [TW-1:0] tap;
  logic loaded;
  logic signed [DATA_WIDTH-1:0] bank [TAPS];
  logic signed [DATA_WIDTH+ACC_GUARD-1:0] acc;
  logic [DATA_WIDTH-1:0] sat;
  logic clear, accept;
  assign bus.w_ready = state == LOAD_W;
  assign bus.pix_ready = state == RUN && tap < TW'(TAPS);
  assign bus.out_valid = state == OUT;
  assign bus.weights_loaded = loaded;
  assign bus.busy = state != IDLE && state != READY;
  assign clear = state == READY && !bus.cfg_load && bus.pix_valid;
  assign accept = bus.pix_valid && bus.pix_ready;
  assign sat = DATA_WIDTH'(saturate(64'(acc), DATA_WIDTH));
`ifdef CONV_SEQ_RELU_EN
  assign bus.out_data = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign bus.out_data = sat;
`endif
  mac_lane #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BIT(FRAC_BIT), .ACC_GUARD(ACC_GUARD)) lane (
    .clk(clk), .reset(reset), .clear(clear), .en(accept),
    .pix(bus.pix_data), .w(bank[tap]), .acc(acc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap <= '0;
      loaded <= 1'b0;
      for (int i = 0; i < TAPS; i++) bank[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cfg_load) begin
          state <= LOAD_W;
          loaded <= 1'b0;
        end
        LOAD_W: if (bus.w_valid) begin
          bank[tap] <= bus.w_data;
          tap <= tap == TW'(TAPS - 1) ? '0 : tap + 1'b1;
          if (tap == TW'(TAPS - 1)) begin
            loaded <= 1'b1;
            state <= READY;
          end
        end
        READY: if (bus.cfg_load) begin
          state <= LOAD_W;
          loaded <= 1'b0;
          tap <= '0;
        end else if (bus.pix_valid) state <= RUN;
        RUN: if (accept) begin
          tap <= tap + 1'b1;
          if (tap == TW'(TAPS - 1)) state <= DRAIN;
        end
        DRAIN: state <= OUT;
        OUT: if (bus.out_ready) begin
          tap <= '0;
          state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: directed self-checking bench for the convolution window sequencer
module tb_conv_window_sequencer;
  import conv_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  conv_window_sequencer_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();
  conv_window_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [15:0] v);
    for (int i = 0; i < TAPS; i++) begin
      int n = 0;
      bus.w_valid = 1'b1;
      bus.w_data = v;
      @(negedge clk);
      while (!bus.w_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("w_ready_timeout", 32'(n), 32'd0);
      step();
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [15:0] v);
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    load_words(v);
    check("weights_loaded", 32'(bus.weights_loaded), 32'd1);
  endtask

  task automatic stream(input logic [15:0] v, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      int n = 0;
      if (gaps) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      bus.pix_valid = 1'b1;
      bus.pix_data = v;
      @(negedge clk);
      while (!bus.pix_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("pix_ready_timeout", 32'(n), 32'd0);
      step();
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic finish_window(input string tag, input logic [15:0] exp, input bit hold);
    @(negedge clk);
    check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_n2"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    if (hold) begin
      bus.pix_valid = 1'b1;
      bus.pix_data = 16'h0100;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(bus.out_data), 32'(exp));
        check({tag, "_hold_pix_ready"}, 32'(bus.pix_ready), 32'd0);
      end
      bus.pix_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_after_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_after_loaded"}, 32'(bus.weights_loaded), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_load = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_w_ready", 32'(bus.w_ready), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_loaded", 32'(bus.weights_loaded), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    step();

    load_weights(16'h0100);
    stream(16'h0100, TAPS, 1'b0);
    finish_window("unity", 16'h1900, 1'b0);

    stream(16'hFF00, TAPS, 1'b0);
`ifdef CONV_SEQ_RELU_EN
    finish_window("negative", 16'h0000, 1'b0);
`else
    finish_window("negative", 16'hE700, 1'b0);
`endif

    stream(16'h0100, TAPS, 1'b1);
    finish_window("gaps_hold", 16'h1900, 1'b1);
    stream(16'h0100, TAPS, 1'b0);
    finish_window("after_hold", 16'h1900, 1'b0);

    load_weights(16'h7FFF);
    stream(16'h7FFF, TAPS, 1'b0);
    finish_window("saturate", 16'h7FFF, 1'b0);

    bus.cfg_load = 1'b1;
    bus.pix_valid = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    check("simul_busy", 32'(bus.busy), 32'd1);
    check("simul_w_ready", 32'(bus.w_ready), 32'd1);
    check("simul_loaded", 32'(bus.weights_loaded), 32'd0);
    check("simul_pix_ready", 32'(bus.pix_ready), 32'd0);
    step();
    load_words(16'h0200);
    check("reload_loaded", 32'(bus.weights_loaded), 32'd1);
    stream(16'h0100, TAPS, 1'b0);
    finish_window("reload", 16'h3200, 1'b0);

    stream(16'h0100, 12, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_w_ready", 32'(bus.w_ready), 32'd0);
    check("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("midrst_loaded", 32'(bus.weights_loaded), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    step();
    load_weights(16'h0100);
    stream(16'h0100, TAPS, 1'b0);
    finish_window("post_reset", 16'h1900, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
